// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 16x16 register file: operand fetch and writeback over valid/ready.
// Optional build macro RF_R0_ZERO_EN: R0 reads as zero and a plain WRITE to R0 needs no RF cycle.
module regfile_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_data_r15,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_op1,
    output logic [DATA_W-1:0] rsp_op2,
    output logic [DATA_W-1:0] rsp_r15,
    output logic              wr_done,
    output logic              rf_read_write_enable,
    output logic [ADDR_W-1:0] rf_register_1,
    output logic [ADDR_W-1:0] rf_register_2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [DATA_W-1:0] rf_write_reg_15,
    input  logic [DATA_W-1:0] rf_read_reg_1,
    input  logic [DATA_W-1:0] rf_read_reg_2,
    input  logic [DATA_W-1:0] rf_read_reg_15
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_CAP,
        ST_RSP,
        ST_WR_R15RD,
        ST_WR_DRIVE
    } state_t;

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_WRITE_R15 = 2'b10;
    localparam logic [1:0] OP_READ_R15  = 2'b11;
    localparam logic [ADDR_W-1:0] R15_IDX = ADDR_W'(15);

    state_t            state_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] data_reg;
    logic              rsp_valid_reg;
    logic              wr_done_reg;
    logic              rwe_reg;
    logic [ADDR_W-1:0] rd_addr1_reg;
    logic [ADDR_W-1:0] rd_addr2_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] wr_r15_reg;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] op2_reg;
    logic [DATA_W-1:0] r15_reg;
    logic              accept;

    assign req_ready = (state_reg == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            dst_reg       <= '0;
            data_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            wr_done_reg   <= 1'b0;
            rwe_reg       <= 1'b1;
            rd_addr1_reg  <= '0;
            rd_addr2_reg  <= '0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            wr_r15_reg    <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            r15_reg       <= '0;
        end else begin
            wr_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        dst_reg  <= req_dst;
                        data_reg <= req_data;
                        case (req_op)
                            OP_READ, OP_READ_R15: begin
                                rd_addr1_reg <= req_src1;
                                rd_addr2_reg <= req_src2;
                                state_reg    <= ST_RD_SETUP;
                            end
                            OP_WRITE: begin
`ifdef RF_R0_ZERO_EN
                                // R0 is invisible to readers, so the write is acknowledged without touching the RF
                                if (req_dst == '0) begin
                                    wr_done_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_WR_R15RD;
                                end
`else
                                state_reg <= ST_WR_R15RD;
`endif
                            end
                            OP_WRITE_R15: begin
                                wr_addr_reg <= req_dst;
                                wr_data_reg <= req_data;
                                wr_r15_reg  <= req_data_r15;
                                rwe_reg     <= 1'b0;
                                state_reg   <= ST_WR_DRIVE;
`ifdef RF_R0_ZERO_EN
                                // read port 1 idles on R0, so R0 is rewritten with its own value
                                if (req_dst == '0) begin
                                    wr_addr_reg <= '0;
                                    wr_data_reg <= rf_read_reg_1;
                                end
`endif
                            end
                            default: state_reg <= ST_IDLE;
                        endcase
                    end
                end
                ST_RD_SETUP: begin
                    state_reg <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
`ifdef RF_R0_ZERO_EN
                    op1_reg <= (rd_addr1_reg == '0) ? '0 : rf_read_reg_1;
                    op2_reg <= (rd_addr2_reg == '0) ? '0 : rf_read_reg_2;
`else
                    op1_reg <= rf_read_reg_1;
                    op2_reg <= rf_read_reg_2;
`endif
                    r15_reg       <= rf_read_reg_15;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
`ifdef RF_R0_ZERO_EN
                        rd_addr1_reg  <= '0;
`endif
                    end
                end
                ST_WR_R15RD: begin
                    // the R15 port writes on every write cycle, so a plain WRITE re-drives the value just read
                    wr_addr_reg <= dst_reg;
                    wr_data_reg <= data_reg;
                    wr_r15_reg  <= (dst_reg == R15_IDX) ? data_reg : rf_read_reg_15;
                    rwe_reg     <= 1'b0;
                    state_reg   <= ST_WR_DRIVE;
                end
                ST_WR_DRIVE: begin
                    rwe_reg     <= 1'b1;
                    wr_done_reg <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    rwe_reg   <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid            = rsp_valid_reg;
    assign rsp_op1              = op1_reg;
    assign rsp_op2              = op2_reg;
    assign rsp_r15              = r15_reg;
    assign wr_done              = wr_done_reg;
    assign rf_read_write_enable = rwe_reg;
    assign rf_register_1        = rd_addr1_reg;
    assign rf_register_2        = rd_addr2_reg;
    assign rf_write_reg         = wr_addr_reg;
    assign rf_write_data        = wr_data_reg;
    assign rf_write_reg_15      = wr_r15_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file plus a shadow-array model of expected contents.
module tb_regfile_access_ctrl;
    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_WRITE_R15 = 2'b10;
    localparam logic [1:0] OP_READ_R15  = 2'b11;
`ifdef RF_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_src1 = 4'd0;
    logic [3:0]  req_src2 = 4'd0;
    logic [3:0]  req_dst = 4'd0;
    logic [15:0] req_data = 16'h0;
    logic [15:0] req_data_r15 = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_op1, rsp_op2, rsp_r15;
    logic        wr_done;
    logic        rf_read_write_enable;
    logic [3:0]  rf_register_1, rf_register_2, rf_write_reg;
    logic [15:0] rf_write_data, rf_write_reg_15;
    logic [15:0] rf_read_reg_1, rf_read_reg_2, rf_read_reg_15;

    logic [15:0] rf_mem [16];
    logic [15:0] rf_init [16];
    logic [15:0] model_rf [16];
    logic        rf_load = 1'b1;
    int          write_count = 0;
    int          check_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
        .req_data(req_data), .req_data_r15(req_data_r15),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op1(rsp_op1), .rsp_op2(rsp_op2), .rsp_r15(rsp_r15),
        .wr_done(wr_done),
        .rf_read_write_enable(rf_read_write_enable),
        .rf_register_1(rf_register_1), .rf_register_2(rf_register_2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write_reg_15(rf_write_reg_15),
        .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
        .rf_read_reg_15(rf_read_reg_15)
    );

    // register file: combinational reads, writes when enable is low; the R15 port wins on a clash
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init[i];
        end else if (!rf_read_write_enable) begin
            rf_mem[rf_write_reg] <= rf_write_data;
            rf_mem[15]           <= rf_write_reg_15;
            write_count          <= write_count + 1;
        end
    end
    assign rf_read_reg_1  = rf_mem[rf_register_1];
    assign rf_read_reg_2  = rf_mem[rf_register_2];
    assign rf_read_reg_15 = rf_mem[15];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [3:0] idx);
        if (R0_ZERO && idx == 4'd0) return 16'h0;
        return model_rf[idx];
    endfunction

    task automatic issue(input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic [15:0] data, input logic [15:0] r15);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
        req_dst = d; req_data = data; req_data_r15 = r15;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [3:0] d, input logic [15:0] data,
                            input logic [15:0] r15, input int rst_at);
        int exp_lat, exp_wr, n, wc0;
        bit done, skip;
        skip    = R0_ZERO && op == OP_WRITE && d == 4'd0;
        exp_lat = skip ? 1 : ((op == OP_WRITE) ? 3 : 2);
        exp_wr  = skip ? 0 : 1;
        wc0     = write_count;
        issue(op, 4'd0, 4'd0, d, data, r15);
        n = 0;
        done = 1'b0;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
            if (n == rst_at) begin
                rst = 1'b1;
                #1 check_val("rst_rwe_high", 64'(rf_read_write_enable), 64'd1);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_val("rst_no_wr_done", 64'(wr_done), 64'd0);
                end
                check_val("rst_ready", 64'(req_ready), 64'd1);
                check_val("rst_write_lost", 64'(write_count - wc0), 64'd0);
                check_val("rst_dst_kept", 64'(rf_mem[d]), 64'(model_rf[d]));
                $display("txn op=%0d dst=%0d data=%h aborted by reset in cycle %0d", op, d, data, n);
                return;
            end
            check_val("rwe_phase", 64'(rf_read_write_enable),
                      (n == exp_lat - 1 && exp_wr == 1) ? 64'd0 : 64'd1);
            if (n == 1 && exp_lat > 1) check_val("busy_ready", 64'(req_ready), 64'd0);
            if (wr_done) done = 1'b1;
        end
        check_val("wr_latency", 64'(n), 64'(exp_lat));
        check_val("ready_in_done", 64'(req_ready), 64'd1);
        if (!(R0_ZERO && d == 4'd0)) model_rf[d] = data;
        if (op == OP_WRITE_R15) model_rf[15] = r15;
        check_val("wr_count", 64'(write_count - wc0), 64'(exp_wr));
        check_val("rf_dst", 64'(rf_mem[d]), 64'(model_rf[d]));
        check_val("rf_r15", 64'(rf_mem[15]), 64'(model_rf[15]));
        @(negedge clk);
        check_val("wr_done_pulse", 64'(wr_done), 64'd0);
        $display("txn op=%0d dst=%0d data=%h r15=%h done_cycle=%0d", op, d, data, r15, n);
    endtask

    task automatic do_read(input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                           input int hold, input bit rst_in_rsp);
        int n;
        logic [47:0] exp;
        exp = {ref_read(s1), ref_read(s2), model_rf[15]};
        issue(op, s1, s2, 4'd0, 16'h0, 16'h0);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) check_val("busy_ready", 64'(req_ready), 64'd0);
        end
        check_val("rd_latency", 64'(n), 64'd3);
        check_val("rsp_op1", 64'(rsp_op1), 64'(exp[47:32]));
        check_val("rsp_op2", 64'(rsp_op2), 64'(exp[31:16]));
        check_val("rsp_r15", 64'(rsp_r15), 64'(exp[15:0]));
        if (rst_in_rsp) begin
            rst = 1'b1;
            #1 check_val("rst_rsp_drop", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            $display("txn op=%0d src1=%0d src2=%0d response lost to reset", op, s1, s2);
            return;
        end
        repeat (hold) begin
            @(negedge clk);
            check_val("rsp_stable", 64'({rsp_valid, rsp_op1, rsp_op2, rsp_r15}), 64'({1'b1, exp}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_val("rsp_dropped", 64'(rsp_valid), 64'd0);
        check_val("rsp_held", 64'({rsp_op1, rsp_op2, rsp_r15}), 64'(exp));
        $display("txn op=%0d src1=%0d src2=%0d op1=%h op2=%h r15=%h hold=%0d",
                 op, s1, s2, exp[47:32], exp[31:16], exp[15:0], hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [1:0] op;
        logic [3:0] a, b, d;
        for (int i = 0; i < 16; i++) rf_init[i] = 16'($urandom);
        rf_init[1]  = 16'h0001;
        rf_init[3]  = 16'h0303;
        rf_init[9]  = 16'h1234;
        rf_init[15] = 16'hAAAA;
        for (int i = 0; i < 16; i++) model_rf[i] = rf_init[i];

        @(negedge clk);
        check_val("reset_rwe", 64'(rf_read_write_enable), 64'd1);
        check_val("reset_ready_low", 64'(req_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rf_load = 1'b0;
        #1;
        check_val("reset_ready", 64'(req_ready), 64'd1);
        check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("reset_wr_done", 64'(wr_done), 64'd0);
        check_val("reset_wdata", 64'(rf_write_data), 64'd0);
        @(negedge clk);
        check_val("reset_no_writes", 64'(write_count), 64'd0);

        do_write(OP_WRITE, 4'd1, 16'hABCD, 16'h0000, 0);
        do_read(OP_READ, 4'd1, 4'd9, 4, 1'b0);
        do_write(OP_WRITE_R15, 4'd7, 16'hBBBB, 16'h1234, 0);
        do_write(OP_WRITE, 4'd15, 16'h5879, 16'h0000, 0);
        do_read(OP_READ_R15, 4'd7, 4'd15, 1, 1'b0);
        do_write(OP_WRITE, 4'd3, 16'hFFFF, 16'h0000, 2);
        do_read(OP_READ, 4'd3, 4'd3, 0, 1'b0);
        do_read(OP_READ, 4'd2, 4'd4, 0, 1'b1);
        do_write(OP_WRITE, 4'd0, 16'h1111, 16'h0000, 0);
        do_read(OP_READ, 4'd0, 4'd9, 0, 1'b0);
        do_write(OP_WRITE_R15, 4'd0, 16'h2222, 16'h3333, 0);
        do_read(OP_READ, 4'd0, 4'd15, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            if (op == OP_WRITE_R15 && d == 4'd15) d = 4'd14;
            if (op == OP_WRITE || op == OP_WRITE_R15)
                do_write(op, d, 16'($urandom), 16'($urandom), 0);
            else
                do_read(op, a, b, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
